// File: rtl/logica_recibir_rtc_hacia_mem_local.sv
// -----------------------------------------------------------------------------
// logica_recibir_rtc_hacia_mem_local
// Read-side sequencer between the RTC interface and the local time/date/timer
// memory. A start pulse launches a burst that requests addresses 0..N_REG-1
// one at a time. Each returned byte is captured into a shadow buffer. Only a
// clean burst (no timeout, no bad BCD) is copied to the outputs, and the copy
// happens in a single cycle, so downstream memory never sees a partial or
// corrupt snapshot.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high
//   start_lectura   1-cycle pulse; starts a burst (ignored while busy)
//   in_dato_rtc     byte returned by the RTC interface
//   in_dato_valido  in_dato_rtc valid this cycle (honoured only while waiting)
//   out_rd_req      1-cycle read request to the RTC interface
//   out_addr_rtc    address of the current request (held between requests)
//   out_busy        high whenever the sequencer is not idle
//   out_done        1-cycle pulse at burst end (success or failure)
//   out_error       sticky timeout/bad-BCD flag, cleared by an accepted start
//   out_seg_hora .. out_hora_timer   committed registers for addresses 0..9
// -----------------------------------------------------------------------------
module logica_recibir_rtc_hacia_mem_local #(
   parameter int N_REG       = 10,
   parameter int TIMEOUT_CYC = 255,
   parameter bit CHECK_BCD   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_lectura,
   input  logic [7:0] in_dato_rtc,
   input  logic       in_dato_valido,
   output logic       out_rd_req,
   output logic [3:0] out_addr_rtc,
   output logic       out_busy,
   output logic       out_done,
   output logic       out_error,
   output logic [7:0] out_seg_hora,
   output logic [7:0] out_min_hora,
   output logic [7:0] out_hora_hora,
   output logic [7:0] out_dia_fecha,
   output logic [7:0] out_mes_fecha,
   output logic [7:0] out_jahr_fecha,
   output logic [7:0] out_dia_semana,
   output logic [7:0] out_seg_timer,
   output logic [7:0] out_min_timer,
   output logic [7:0] out_hora_timer
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_ABORT  = 3'd4
   } state_t;

   localparam logic [3:0] LAST_IDX   = 4'(N_REG - 1);
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

   state_t     r_state;
   state_t     w_state_n;
   logic [3:0] r_idx;
   logic [7:0] r_timer;
   logic       r_bad;
   logic       r_rd_req;
   logic       r_busy;
   logic       r_done;
   logic       r_error;
   logic [7:0] r_shadow [0:N_REG-1];
   logic [7:0] r_out    [0:N_REG-1];
   logic [7:0] w_out    [0:9];
   logic       w_last;
   logic       w_expira;
   logic       w_dato_malo;

   // A byte is not valid BCD when either nibble exceeds 9.
   function automatic logic f_bcd_invalido(input logic [7:0] dato);
      return (dato[7:4] > 4'd9) || (dato[3:0] > 4'd9);
   endfunction

   assign w_last      = (r_idx == LAST_IDX);
   assign w_expira    = (r_timer == TIMER_LAST);
   assign w_dato_malo = CHECK_BCD && f_bcd_invalido(in_dato_rtc);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   // Next-state logic; returned data takes priority over timer expiry.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start_lectura) w_state_n = ST_REQ;
            else               w_state_n = ST_IDLE;
         end
         ST_REQ: begin
            w_state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (in_dato_valido) begin
               if (w_last) w_state_n = ST_COMMIT;
               else        w_state_n = ST_REQ;
            end else if (w_expira) begin
               w_state_n = ST_ABORT;
            end else begin
               w_state_n = ST_WAIT;
            end
         end
         ST_COMMIT: w_state_n = ST_IDLE;
         ST_ABORT:  w_state_n = ST_IDLE;
         default:   w_state_n = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs; rd_req/busy are derived from the next
   // state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx    <= 4'd0;
         r_timer  <= 8'd0;
         r_bad    <= 1'b0;
         r_rd_req <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         for (int i = 0; i < N_REG; i++) begin
            r_shadow[i] <= 8'd0;
            r_out[i]    <= 8'd0;
         end
      end else begin
         r_rd_req <= (w_state_n == ST_REQ);
         r_busy   <= (w_state_n != ST_IDLE);
         r_done   <= (r_state == ST_COMMIT) || (r_state == ST_ABORT);
         case (r_state)
            ST_IDLE: begin
               if (start_lectura) begin
                  r_idx   <= 4'd0;
                  r_bad   <= 1'b0;
                  r_error <= 1'b0;
               end
            end
            ST_REQ: begin
               r_timer <= 8'd0;
            end
            ST_WAIT: begin
               if (in_dato_valido) begin
                  r_shadow[r_idx] <= in_dato_rtc;
                  if (w_dato_malo) r_bad <= 1'b1;
                  if (!w_last)     r_idx <= r_idx + 4'd1;
               end else if (!w_expira) begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            ST_COMMIT: begin
               if (!r_bad) begin
                  for (int i = 0; i < N_REG; i++) r_out[i] <= r_shadow[i];
               end else begin
                  r_error <= 1'b1;
               end
            end
            ST_ABORT: begin
               r_error <= 1'b1;
            end
            default: begin
               r_error <= r_error;
            end
         endcase
      end
   end

   // Map committed registers onto the ten named outputs; unused slots read 0.
   for (genvar g = 0; g < 10; g++) begin : g_map
      if (g < N_REG) begin : g_on
         assign w_out[g] = r_out[g];
      end else begin : g_off
         assign w_out[g] = 8'd0;
      end
   end

   assign out_rd_req     = r_rd_req;
   assign out_addr_rtc   = r_idx;
   assign out_busy       = r_busy;
   assign out_done       = r_done;
   assign out_error      = r_error;
   assign out_seg_hora   = w_out[0];
   assign out_min_hora   = w_out[1];
   assign out_hora_hora  = w_out[2];
   assign out_dia_fecha  = w_out[3];
   assign out_mes_fecha  = w_out[4];
   assign out_jahr_fecha = w_out[5];
   assign out_dia_semana = w_out[6];
   assign out_seg_timer  = w_out[7];
   assign out_min_timer  = w_out[8];
   assign out_hora_timer = w_out[9];

endmodule

// File: tb/tb_logica_recibir_rtc_hacia_mem_local.sv
module tb_logica_recibir_rtc_hacia_mem_local;

   localparam int TOUT = 255;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_lectura;
   logic [7:0] in_dato_rtc;
   logic       in_dato_valido;

   logic       rd_req_a, busy_a, done_a, error_a;
   logic [3:0] addr_a;
   logic [7:0] out_a [10];
   logic       rd_req_b, busy_b, done_b, error_b;
   logic [3:0] addr_b;
   logic [7:0] out_b [10];

   int n_checks = 0;
   int n_errors = 0;

   // reference model: committed memory and sticky error per DUT
   logic [7:0] mem_a [10];
   logic [7:0] mem_b [10];
   bit         err_a, err_b;

   // burst description
   logic [7:0] b_bytes [10];
   int         b_dly [10];
   int         b_drop;
   bit         b_noise;
   bit         b_restart;

   always #5 clk = ~clk;

   logica_recibir_rtc_hacia_mem_local #(.N_REG(10), .TIMEOUT_CYC(TOUT), .CHECK_BCD(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start_lectura(start_lectura),
      .in_dato_rtc(in_dato_rtc), .in_dato_valido(in_dato_valido),
      .out_rd_req(rd_req_a), .out_addr_rtc(addr_a), .out_busy(busy_a),
      .out_done(done_a), .out_error(error_a),
      .out_seg_hora(out_a[0]), .out_min_hora(out_a[1]), .out_hora_hora(out_a[2]),
      .out_dia_fecha(out_a[3]), .out_mes_fecha(out_a[4]), .out_jahr_fecha(out_a[5]),
      .out_dia_semana(out_a[6]), .out_seg_timer(out_a[7]), .out_min_timer(out_a[8]),
      .out_hora_timer(out_a[9])
   );

   logica_recibir_rtc_hacia_mem_local #(.N_REG(10), .TIMEOUT_CYC(TOUT), .CHECK_BCD(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start_lectura(start_lectura),
      .in_dato_rtc(in_dato_rtc), .in_dato_valido(in_dato_valido),
      .out_rd_req(rd_req_b), .out_addr_rtc(addr_b), .out_busy(busy_b),
      .out_done(done_b), .out_error(error_b),
      .out_seg_hora(out_b[0]), .out_min_hora(out_b[1]), .out_hora_hora(out_b[2]),
      .out_dia_fecha(out_b[3]), .out_mes_fecha(out_b[4]), .out_jahr_fecha(out_b[5]),
      .out_dia_semana(out_b[6]), .out_seg_timer(out_b[7]), .out_min_timer(out_b[8]),
      .out_hora_timer(out_b[9])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_bad_bcd(input logic [7:0] x);
      int v;
      v = int'(x);
      return ((v / 16) > 9) || ((v % 16) > 9);
   endfunction

   task automatic chk_outs();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("out_a[%0d]", i), out_a[i], mem_a[i]);
         chk($sformatf("out_b[%0d]", i), out_b[i], mem_b[i]);
      end
      chk("error_a", error_a, err_a);
      chk("error_b", error_b, err_b);
   endtask

   // idle cycles with junk on the data inputs (must be ignored in IDLE)
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start_lectura  = 1'b0;
         in_dato_valido = 1'($urandom);
         in_dato_rtc    = 8'($urandom);
         chk("idle_done", done_a | done_b, 1'b0);
         chk("idle_busy", busy_a | busy_b, 1'b0);
      end
   endtask

   // start_lectura is already high when called; acts as the RTC responder
   task automatic run_burst();
      int  exp_done, exp_req, exp_last, prior;
      int  nreq, wait_cnt, cur, cyc;
      bit  pending, got_done, any_bad;

      prior = 0;
      exp_done = -1;
      for (int i = 0; i < 10; i++) begin
         if (i == b_drop && exp_done < 0) exp_done = prior + 1 + TOUT + 1;
         prior += 2 + b_dly[i];
      end
      if (b_drop < 0) begin
         exp_done = prior + 1;
         exp_req  = 10;
         exp_last = 9;
      end else begin
         exp_req  = b_drop + 1;
         exp_last = b_drop;
      end
      err_a = 1'b0;
      err_b = 1'b0;

      pending = 1'b0; nreq = 0; got_done = 1'b0; wait_cnt = 0; cur = 0;
      for (cyc = 0; cyc < 700; cyc++) begin
         @(posedge clk); #1;
         start_lectura  = 1'b0;
         in_dato_valido = 1'b0;
         in_dato_rtc    = 8'($urandom);
         if (cyc == 0) begin
            chk("busy_start", busy_a & busy_b, 1'b1);
            chk("err_clear", error_a | error_b, 1'b0);
            chk("done_low", done_a | done_b, 1'b0);
         end
         if (pending) begin
            if (wait_cnt == 0) begin
               in_dato_valido = 1'b1;
               in_dato_rtc    = b_bytes[cur];
               pending        = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
         if (rd_req_a) begin
            chk("addr", addr_a, nreq);
            chk("addr_b", addr_b, nreq);
            chk("req_b", rd_req_b, 1'b1);
            cur = nreq;
            nreq++;
            if (cur != b_drop) begin
               pending  = 1'b1;
               wait_cnt = b_dly[cur];
            end
            if (b_noise && !in_dato_valido) begin
               in_dato_valido = 1'b1;
               in_dato_rtc    = 8'hFF;
            end
            if (b_restart && cur == 3) start_lectura = 1'b1;
         end
         if (done_a || done_b) begin
            got_done = 1'b1;
            break;
         end
      end

      chk("done_seen", got_done, 1'b1);
      chk("done_cycle", cyc, exp_done);
      chk("done_both", done_a & done_b, 1'b1);
      chk("req_count", nreq, exp_req);
      chk("addr_hold", addr_a, exp_last);
      chk("busy_end", busy_a | busy_b, 1'b0);

      if (b_drop >= 0) begin
         err_a = 1'b1;
         err_b = 1'b1;
      end else begin
         any_bad = 1'b0;
         for (int i = 0; i < 10; i++) if (is_bad_bcd(b_bytes[i])) any_bad = 1'b1;
         if (any_bad) err_a = 1'b1;
         else for (int i = 0; i < 10; i++) mem_a[i] = b_bytes[i];
         for (int i = 0; i < 10; i++) mem_b[i] = b_bytes[i];
      end
      chk_outs();
   endtask

   task automatic do_burst(input bit chain);
      if (!chain) idle(2);
      start_lectura = 1'b1;
      run_burst();
   endtask

   task automatic plain_spec();
      for (int i = 0; i < 10; i++) begin
         b_bytes[i] = 8'(i);
         b_dly[i]   = 0;
      end
      b_drop = -1; b_noise = 1'b0; b_restart = 1'b0;
   endtask

   initial begin
      bit pend;
      bit chain;
      reset = 1'b1; start_lectura = 1'b0; in_dato_valido = 1'b0; in_dato_rtc = 8'h00;
      for (int i = 0; i < 10; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      err_a = 1'b0; err_b = 1'b0;
      #12;
      chk_outs();
      chk("rst_busy", busy_a | busy_b, 1'b0);
      chk("rst_done", done_a | done_b, 1'b0);
      chk("rst_req", rd_req_a | rd_req_b, 1'b0);
      chk("rst_addr", addr_a, 4'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: address n returns n, immediate answers
      plain_spec();
      do_burst(1'b0);
      idle(1);

      // 2: all 8'h12, then 8'h3A at addr 4
      plain_spec();
      for (int i = 0; i < 10; i++) b_bytes[i] = 8'h12;
      do_burst(1'b0);
      b_bytes[4] = 8'h3A;
      do_burst(1'b1);

      // 3: addr 6 never answered, then a clean burst clears the error
      plain_spec();
      b_drop = 6;
      do_burst(1'b0);
      plain_spec();
      b_dly[2] = 3;
      do_burst(1'b0);

      // 4: restart pulse at addr 3 plus junk valid in REQ
      plain_spec();
      for (int i = 0; i < 10; i++) b_bytes[i] = 8'(16 * (i % 10) + 9 - i);
      do_burst(1'b0);
      plain_spec();
      b_noise = 1'b1; b_restart = 1'b1;
      do_burst(1'b0);
      idle(3);

      // 5: reset while waiting at addr 5
      plain_spec();
      start_lectura = 1'b1;
      pend = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         start_lectura  = 1'b0;
         in_dato_valido = pend;
         in_dato_rtc    = pend ? 8'h55 : 8'($urandom);
         pend = 1'b0;
         if (rd_req_a) begin
            if (addr_a == 4'd5) break;
            pend = 1'b1;
         end
      end
      chk("rst_at5_addr", addr_a, 4'd5);
      @(posedge clk); #1;
      in_dato_valido = 1'b0;
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      err_a = 1'b0; err_b = 1'b0;
      chk_outs();
      chk("mid_rst_busy", busy_a | busy_b, 1'b0);
      chk("mid_rst_done", done_a | done_b, 1'b0);
      chk("mid_rst_addr", addr_a, 4'd0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_hold_done", done_a | done_b, 1'b0);
      end
      reset = 1'b0;
      plain_spec();
      do_burst(1'b0);

      // 6: valid on the last permitted WAIT cycle at addr 0; 8'hFF at addr 7
      plain_spec();
      b_dly[0] = TOUT - 1;
      b_bytes[7] = 8'hFF;
      do_burst(1'b0);

      // random bursts
      chain = 1'b0;
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 10; i++) begin
            b_bytes[i] = 8'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
            b_dly[i]   = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 2);
         end
         if ($urandom_range(0, 3) == 0) b_bytes[$urandom_range(0, 9)] = 8'($urandom);
         b_drop    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1;
         b_noise   = 1'($urandom);
         b_restart = 1'($urandom);
         do_burst(chain);
         chain = 1'($urandom);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
